id_ex_stage: RTL and testbench

Pipeline register between instruction decode and the ALU in the reduced RISC-V core. Captures decoded control and operands with a valid/ready handshake and applies EX/MEM and MEM/WB forwarding to the register operands. Detects load-use hazards and inserts a bubble, and honours a branch flush. Drives `alusrc`, `aluctrl`, `aluop1`, `immop` and `regop2` of the ALU directly.

---
 rtl/riscv_pkg.sv | 29 ++
 rtl/forward_unit.sv | 31 +++
 rtl/id_ex_stage.sv | 128 ++++++++++++
 tb/tb_id_ex_stage.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the reduced RISC-V core pipeline.
package riscv_pkg;

    localparam int RA_W = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011
    } aluctrl_e;

    typedef enum logic [1:0] {
        FWD_REG,
        FWD_EXMEM,
        FWD_MEMWB
    } fwd_sel_e;

    // aluctrl stays a raw 3-bit field so reserved codes travel through untouched
    typedef struct packed {
        logic       alusrc;
        logic [2:0] aluctrl;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
    } id_ex_ctrl_t;

endpackage

// File: rtl/forward_unit.sv
// Operand forwarding mux: picks the newest in-flight value for one source register.
module forward_unit #(
    parameter int D_WIDTH = 32,
    parameter int RA_W    = riscv_pkg::RA_W
) (
    input  logic [RA_W-1:0]    rs,
    input  logic [D_WIDTH-1:0] rdata,
    input  logic               exmem_regwrite,
    input  logic [RA_W-1:0]    exmem_rd,
    input  logic [D_WIDTH-1:0] exmem_result,
    input  logic               memwb_regwrite,
    input  logic [RA_W-1:0]    memwb_rd,
    input  logic [D_WIDTH-1:0] memwb_result,
    output logic [D_WIDTH-1:0] value,
    output riscv_pkg::fwd_sel_e sel
);

    // EX/MEM is younger than MEM/WB, so it is checked first; x0 is never forwarded
    always_comb begin
        sel   = riscv_pkg::FWD_REG;
        value = rdata;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rs)) begin
            sel   = riscv_pkg::FWD_EXMEM;
            value = exmem_result;
        end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs)) begin
            sel   = riscv_pkg::FWD_MEMWB;
            value = memwb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, operand forwarding,
// load-use bubble insertion and branch flush.
module id_ex_stage #(
    parameter int D_WIDTH = 32,
    parameter int RA_W    = riscv_pkg::RA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [D_WIDTH-1:0] in_pc,
    input  logic [D_WIDTH-1:0] in_rdata1,
    input  logic [D_WIDTH-1:0] in_rdata2,
    input  logic [D_WIDTH-1:0] in_imm,
    input  logic [RA_W-1:0]    in_rs1,
    input  logic [RA_W-1:0]    in_rs2,
    input  logic [RA_W-1:0]    in_rd,
    input  logic               in_alusrc,
    input  logic [2:0]         in_aluctrl,
    input  logic               in_regwrite,
    input  logic               in_memread,
    input  logic               in_memwrite,
    input  logic               in_branch,
    input  logic               flush,
    input  logic               exmem_regwrite,
    input  logic [RA_W-1:0]    exmem_rd,
    input  logic [D_WIDTH-1:0] exmem_result,
    input  logic               memwb_regwrite,
    input  logic [RA_W-1:0]    memwb_rd,
    input  logic [D_WIDTH-1:0] memwb_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               alusrc,
    output logic [2:0]         aluctrl,
    output logic [D_WIDTH-1:0] aluop1,
    output logic [D_WIDTH-1:0] immop,
    output logic [D_WIDTH-1:0] regop2,
    output logic [D_WIDTH-1:0] out_pc,
    output logic [RA_W-1:0]    out_rd,
    output logic               out_regwrite,
    output logic               out_memread,
    output logic               out_memwrite,
    output logic               out_branch
);

    riscv_pkg::id_ex_ctrl_t ctrl_q;
    logic [D_WIDTH-1:0]     pc_q, rdata1_q, rdata2_q, imm_q;
    logic [RA_W-1:0]        rs1_q, rs2_q, rd_q;
    logic                   lu;
    logic                   accept;

    // A held load whose destination feeds the incoming instruction must drain first
    assign lu = out_valid & ctrl_q.memread & (rd_q != '0) & in_valid
              & ((in_rs1 == rd_q) | (in_rs2 == rd_q));
    assign in_ready = (~out_valid | out_ready) & ~lu;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            ctrl_q    <= '0;
            pc_q      <= '0;
            rdata1_q  <= '0;
            rdata2_q  <= '0;
            imm_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            ctrl_q    <= '{alusrc:   in_alusrc,
                           aluctrl:  in_aluctrl,
                           regwrite: in_regwrite,
                           memread:  in_memread,
                           memwrite: in_memwrite,
                           branch:   in_branch};
            pc_q      <= in_pc;
            rdata1_q  <= in_rdata1;
            rdata2_q  <= in_rdata2;
            imm_q     <= in_imm;
            rs1_q     <= in_rs1;
            rs2_q     <= in_rs2;
            rd_q      <= in_rd;
        end else if (out_valid & out_ready) begin
            // covers both a normal drain and the load-use bubble
            out_valid <= 1'b0;
        end
    end

    forward_unit #(.D_WIDTH(D_WIDTH), .RA_W(RA_W)) u_fwd1 (
        .rs             (rs1_q),
        .rdata          (rdata1_q),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_result   (memwb_result),
        .value          (aluop1),
        .sel            ()
    );

    forward_unit #(.D_WIDTH(D_WIDTH), .RA_W(RA_W)) u_fwd2 (
        .rs             (rs2_q),
        .rdata          (rdata2_q),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_result   (memwb_result),
        .value          (regop2),
        .sel            ()
    );

    assign immop        = imm_q;
    assign alusrc       = ctrl_q.alusrc;
    assign aluctrl      = ctrl_q.aluctrl;
    assign out_pc       = pc_q;
    assign out_rd       = rd_q;
    assign out_regwrite = out_valid & ctrl_q.regwrite;
    assign out_memread  = out_valid & ctrl_q.memread;
    assign out_memwrite = out_valid & ctrl_q.memwrite;
    assign out_branch   = out_valid & ctrl_q.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed scenarios followed by random traffic
// checked against a queue-based model of the stage.
module tb_id_ex_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        alusrc;
        logic [2:0]  aluctrl;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        branch;
    } instr_t;

    typedef struct packed {
        logic        valid;
        logic        ordy;
        logic        fl;
        logic        r;
        logic        exw;
        logic [4:0]  exrd;
        logic [31:0] exres;
        logic        mww;
        logic [4:0]  mwrd;
        logic [31:0] mwres;
    } env_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_rdata1, in_rdata2, in_imm;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_alusrc;
    logic [2:0]  in_aluctrl;
    logic        in_regwrite, in_memread, in_memwrite, in_branch;
    logic        flush;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        out_valid, out_ready;
    logic        alusrc;
    logic [2:0]  aluctrl;
    logic [31:0] aluop1, immop, regop2, out_pc;
    logic [4:0]  out_rd;
    logic        out_regwrite, out_memread, out_memwrite, out_branch;

    // Instructions the stage currently holds (at most one), oldest first
    instr_t sb[$];
    logic   exp_in_ready;
    logic   mon_en = 1'b0;
    int     n_cmp  = 0;
    int     n_fail = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.D_WIDTH(32), .RA_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rdata1(in_rdata1), .in_rdata2(in_rdata2), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_alusrc(in_alusrc), .in_aluctrl(in_aluctrl),
        .in_regwrite(in_regwrite), .in_memread(in_memread),
        .in_memwrite(in_memwrite), .in_branch(in_branch),
        .flush(flush),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .alusrc(alusrc), .aluctrl(aluctrl),
        .aluop1(aluop1), .immop(immop), .regop2(regop2),
        .out_pc(out_pc), .out_rd(out_rd),
        .out_regwrite(out_regwrite), .out_memread(out_memread),
        .out_memwrite(out_memwrite), .out_branch(out_branch)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Newest producer wins; register x0 always reads its own value
    function automatic logic [31:0] fwdVal(input logic [4:0] rs, input logic [31:0] rdata);
        if (rs != 5'd0 && exmem_regwrite && exmem_rd == rs) return exmem_result;
        if (rs != 5'd0 && memwb_regwrite && memwb_rd == rs) return memwb_result;
        return rdata;
    endfunction

    function automatic instr_t randInstr();
        instr_t i;
        i.pc       = $urandom;
        i.rdata1   = $urandom;
        i.rdata2   = $urandom;
        i.imm      = $urandom;
        i.rs1      = 5'($urandom_range(0, 7));
        i.rs2      = 5'($urandom_range(0, 7));
        i.rd       = 5'($urandom_range(0, 7));
        i.alusrc   = 1'($urandom);
        i.aluctrl  = 3'($urandom_range(0, 7));
        i.regwrite = 1'($urandom);
        i.memread  = ($urandom_range(0, 99) < 30);
        i.memwrite = 1'($urandom);
        i.branch   = 1'($urandom);
        return i;
    endfunction

    function automatic env_t mkEnv(input logic v, input logic ordy);
        env_t e;
        e       = '0;
        e.valid = v;
        e.ordy  = ordy;
        return e;
    endfunction

    function automatic env_t randEnv();
        env_t e;
        e.valid = ($urandom_range(0, 99) < 75);
        e.ordy  = ($urandom_range(0, 99) < 70);
        e.fl    = ($urandom_range(0, 99) < 8);
        e.r     = ($urandom_range(0, 99) < 2);
        e.exw   = 1'($urandom);
        e.exrd  = 5'($urandom_range(0, 7));
        e.exres = $urandom;
        e.mww   = 1'($urandom);
        e.mwrd  = 5'($urandom_range(0, 7));
        e.mwres = $urandom;
        return e;
    endfunction

    // Drive one cycle of inputs; record the instruction if the stage takes and keeps it
    task automatic applyStimulus(input instr_t i, input env_t e);
        @(posedge clk);
        #1;
        in_valid       = e.valid;
        out_ready      = e.ordy;
        flush          = e.fl;
        rst            = e.r;
        exmem_regwrite = e.exw;
        exmem_rd       = e.exrd;
        exmem_result   = e.exres;
        memwb_regwrite = e.mww;
        memwb_rd       = e.mwrd;
        memwb_result   = e.mwres;
        in_pc          = i.pc;
        in_rdata1      = i.rdata1;
        in_rdata2      = i.rdata2;
        in_imm         = i.imm;
        in_rs1         = i.rs1;
        in_rs2         = i.rs2;
        in_rd          = i.rd;
        in_alusrc      = i.alusrc;
        in_aluctrl     = i.aluctrl;
        in_regwrite    = i.regwrite;
        in_memread     = i.memread;
        in_memwrite    = i.memwrite;
        in_branch      = i.branch;
        @(negedge clk);
        #1;
        if (!e.r && !e.fl && e.valid && exp_in_ready) sb.push_back(i);
    endtask

    // Compare DUT against the held instruction, then retire it if consumed
    task automatic checkOutput();
        instr_t h;
        logic   has, lu_exp;
        has = (sb.size() != 0);
        h   = has ? sb[0] : '0;
        lu_exp = has && h.memread && (h.rd != 5'd0) && in_valid
                 && (in_rs1 == h.rd || in_rs2 == h.rd);
        exp_in_ready = (!has || out_ready) && !lu_exp;
        cmp("in_ready", 32'(in_ready), 32'(exp_in_ready));
        cmp("out_valid", 32'(out_valid), 32'(has));
        cmp("out_regwrite", 32'(out_regwrite), 32'(has & h.regwrite));
        cmp("out_memread", 32'(out_memread), 32'(has & h.memread));
        cmp("out_memwrite", 32'(out_memwrite), 32'(has & h.memwrite));
        cmp("out_branch", 32'(out_branch), 32'(has & h.branch));
        if (has) begin
            cmp("alusrc", 32'(alusrc), 32'(h.alusrc));
            cmp("aluctrl", 32'(aluctrl), 32'(h.aluctrl));
            cmp("aluop1", aluop1, fwdVal(h.rs1, h.rdata1));
            cmp("regop2", regop2, fwdVal(h.rs2, h.rdata2));
            cmp("immop", immop, h.imm);
            cmp("out_pc", out_pc, h.pc);
            cmp("out_rd", 32'(out_rd), 32'(h.rd));
        end
        if (rst || flush) sb.delete();
        else if (has && out_ready) void'(sb.pop_front());
    endtask

    always @(negedge clk) if (mon_en) checkOutput();

    initial begin
        instr_t i, ld;
        env_t   e;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        in_pc = '0; in_rdata1 = '0; in_rdata2 = '0; in_imm = '0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_alusrc = 1'b0; in_aluctrl = '0;
        in_regwrite = 1'b0; in_memread = 1'b0; in_memwrite = 1'b0; in_branch = 1'b0;
        exmem_regwrite = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_regwrite = 1'b0; memwb_rd = '0; memwb_result = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cmp("rst out_valid", 32'(out_valid), 32'd0);
        cmp("rst in_ready", 32'(in_ready), 32'd1);
        cmp("rst aluop1", aluop1, 32'd0);
        cmp("rst regop2", regop2, 32'd0);
        cmp("rst immop", immop, 32'd0);
        cmp("rst out_pc", out_pc, 32'd0);
        cmp("rst out_rd", 32'(out_rd), 32'd0);
        cmp("rst aluctrl", 32'(aluctrl), 32'd0);
        cmp("rst alusrc", 32'(alusrc), 32'd0);
        cmp("rst regwrite", 32'(out_regwrite), 32'd0);
        cmp("rst memread", 32'(out_memread), 32'd0);
        cmp("rst memwrite", 32'(out_memwrite), 32'd0);
        cmp("rst branch", 32'(out_branch), 32'd0);
        mon_en = 1'b1;

        // Back-to-back ADD with no forwarding
        i = randInstr(); i.rs1 = 5'd1; i.rs2 = 5'd2; i.rdata1 = 32'd5; i.rdata2 = 32'd7;
        i.alusrc = 1'b0; i.aluctrl = 3'b000; i.memread = 1'b0;
        applyStimulus(i, mkEnv(1'b1, 1'b1));
        i.pc = 32'h40;
        applyStimulus(i, mkEnv(1'b1, 1'b1));
        applyStimulus(i, mkEnv(1'b0, 1'b1));

        // Forward priority on a held rs1=3, then x0 never forwarded
        i = randInstr(); i.rs1 = 5'd3; i.rdata1 = 32'h11; i.memread = 1'b0;
        applyStimulus(i, mkEnv(1'b1, 1'b1));
        e = mkEnv(1'b0, 1'b0);
        e.exw = 1'b1; e.exrd = 5'd3; e.exres = 32'hAA;
        e.mww = 1'b1; e.mwrd = 5'd3; e.mwres = 32'hBB;
        applyStimulus(i, e);
        e.exw = 1'b0;
        applyStimulus(i, e);
        applyStimulus(i, mkEnv(1'b0, 1'b1));
        i.rs1 = 5'd0; i.rdata1 = 32'h55;
        applyStimulus(i, mkEnv(1'b1, 1'b1));
        e = mkEnv(1'b0, 1'b1);
        e.exw = 1'b1; e.exrd = 5'd0; e.exres = 32'hAA;
        e.mww = 1'b1; e.mwrd = 5'd0; e.mwres = 32'hBB;
        applyStimulus(i, e);

        // Load-use: LW x4 then a consumer of x4
        ld = randInstr(); ld.rd = 5'd4; ld.memread = 1'b1;
        applyStimulus(ld, mkEnv(1'b1, 1'b1));
        i = randInstr(); i.rs1 = 5'd1; i.rs2 = 5'd4; i.memread = 1'b0;
        repeat (3) applyStimulus(i, mkEnv(1'b1, 1'b1));

        // Downstream stall for three cycles, then release
        i = randInstr(); i.memread = 1'b0;
        applyStimulus(i, mkEnv(1'b1, 1'b1));
        i = randInstr(); i.memread = 1'b0;
        repeat (3) applyStimulus(i, mkEnv(1'b1, 1'b0));
        repeat (2) applyStimulus(i, mkEnv(1'b1, 1'b1));

        // Flush with a held and an incoming instruction
        i = randInstr(); i.memwrite = 1'b1; i.memread = 1'b0;
        applyStimulus(i, mkEnv(1'b1, 1'b0));
        e = mkEnv(1'b1, 1'b0); e.fl = 1'b1;
        applyStimulus(i, e);
        applyStimulus(i, mkEnv(1'b0, 1'b1));

        // Reset while an instruction is held
        i = randInstr();
        applyStimulus(i, mkEnv(1'b1, 1'b0));
        e = mkEnv(1'b0, 1'b0); e.r = 1'b1;
        applyStimulus(i, e);
        applyStimulus(i, mkEnv(1'b0, 1'b0));

        for (int n = 0; n < 3000; n++) applyStimulus(randInstr(), randEnv());
        repeat (3) applyStimulus(randInstr(), mkEnv(1'b0, 1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
